// File: rtl/lamp_ctrl_multi.sv
// Multi-switch lamp controller: several wall switches share one lamp.
// Any switch flip is an event; the lamp runs either a timed on-period with
// a buzzer pre-warning, or a latched toggle mode with no timeout.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   OFF   | lamp dark, counter parked at 0
//   ON_T  | timed on-period, counter runs 0..C_MAX-1, buzzer in last WARN
//   ON_L  | latched on, no timeout, counter held
module lamp_ctrl_multi #(
   parameter int unsigned          N_SW  = 3,
   parameter int unsigned          C_NUM = 28,
   parameter logic [C_NUM-1:0]     C_MAX = 28'hFFF_FFFF,
   parameter logic [C_NUM-1:0]     WARN  = 28'h100_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_SW-1:0] S,
   input  logic            mode,
   output logic            F,
   output logic            Buzzer,
   output logic [6:0]      LED
);

   typedef enum logic [1:0] {
      ST_OFF = 2'd0,
      ST_ON_T = 2'd1,
      ST_ON_L = 2'd2
   } state_t;

   // Last count value of the on-period, and first count that sounds the buzzer.
   localparam logic [C_NUM-1:0] CNT_LAST  = C_MAX - 1'b1;
   localparam logic [C_NUM-1:0] BUZ_START = C_MAX - WARN;

   localparam logic [6:0] LED_BLANK = 7'b1111111;
   localparam logic [6:0] LED_ONE   = 7'b1111001;
   localparam logic [6:0] LED_L     = 7'b1000111;

   state_t           state_q, state_d;
   logic [C_NUM-1:0] count_q, count_d;
   logic             p_q;
   logic             p;
   logic             sw_event;

   // Parity of all switches changes on any single flip, so an edge on the
   // parity is one event regardless of which switch moved.
   assign p        = ^S;
   assign sw_event = p ^ p_q;

   // State, counter and parity history; reset preloads the parity history
   // so releasing reset never looks like a switch flip.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_OFF;
         count_q <= '0;
         p_q     <= p;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         p_q     <= p;
      end
   end

   // Next-state and counter update; an event always takes priority over timeout.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      unique case (state_q)
         ST_OFF: begin
            count_d = '0;
            if (sw_event) begin
               state_d = mode ? ST_ON_L : ST_ON_T;
            end
         end
         ST_ON_T: begin
            if (sw_event) begin
               if (mode) begin
                  state_d = ST_OFF;
               end
               count_d = '0;
            end else if (mode) begin
               state_d = ST_ON_L;
            end else if (count_q == CNT_LAST) begin
               state_d = ST_OFF;
               count_d = '0;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         ST_ON_L: begin
            if (sw_event) begin
               state_d = ST_OFF;
               count_d = '0;
            end else if (!mode) begin
               state_d = ST_ON_T;
               count_d = '0;
            end
         end
         default: begin
            state_d = ST_OFF;
            count_d = '0;
         end
      endcase
   end

   // Output decode from registered state and count only.
   always_comb begin
      F      = 1'b0;
      Buzzer = 1'b0;
      LED    = LED_BLANK;
      unique case (state_q)
         ST_ON_T: begin
            F      = 1'b1;
            Buzzer = (count_q >= BUZ_START);
            LED    = LED_ONE;
         end
         ST_ON_L: begin
            F   = 1'b1;
            LED = LED_L;
         end
         default: begin
            F      = 1'b0;
            Buzzer = 1'b0;
            LED    = LED_BLANK;
         end
      endcase
   end

endmodule

// File: tb/tb_lamp_ctrl_multi.sv
// Bench for lamp_ctrl_multi: directed scenarios then random switch/mode/reset
// traffic, all compared against a remaining-time model of the lamp.
module tb_lamp_ctrl_multi;

   localparam int         N_SW  = 3;
   localparam int         C_NUM = 5;
   localparam int         CMAX  = 16;
   localparam int         CWARN = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [N_SW-1:0]  S;
   logic             mode;
   logic             F;
   logic             Buzzer;
   logic [6:0]       LED;

   int checks   = 0;
   int failures = 0;

   // Model: 0 = dark, 1 = timed (left = cycles of light remaining), 2 = latched.
   int   m_kind  = 0;
   int   m_left  = 0;
   logic m_pprev = 1'b0;

   int hi_cnt;
   int buz_cnt;

   lamp_ctrl_multi #(
      .N_SW (N_SW),
      .C_NUM(C_NUM),
      .C_MAX(5'd16),
      .WARN (5'd4)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .S     (S),
      .mode  (mode),
      .F     (F),
      .Buzzer(Buzzer),
      .LED   (LED)
   );

   always #5 clk = ~clk;

   task automatic step(input string tag);
      logic       p;
      logic       ev;
      logic       exp_f;
      logic       exp_b;
      logic [6:0] exp_led;
      @(posedge clk);
      p = ^S;
      if (rst) begin
         m_kind  = 0;
         m_left  = 0;
         m_pprev = p;
      end else begin
         ev      = (p != m_pprev);
         m_pprev = p;
         if (m_kind == 0) begin
            if (ev) begin
               if (mode) m_kind = 2;
               else begin
                  m_kind = 1;
                  m_left = CMAX;
               end
            end
         end else if (m_kind == 1) begin
            if (ev) begin
               if (mode) m_kind = 0;
               else m_left = CMAX;
            end else if (mode) begin
               m_kind = 2;
            end else if (m_left == 1) begin
               m_kind = 0;
            end else begin
               m_left = m_left - 1;
            end
         end else begin
            if (ev) m_kind = 0;
            else if (!mode) begin
               m_kind = 1;
               m_left = CMAX;
            end
         end
      end
      exp_f   = (m_kind != 0);
      exp_b   = (m_kind == 1) && (m_left <= CWARN);
      exp_led = (m_kind == 0) ? 7'b1111111 : (m_kind == 1) ? 7'b1111001 : 7'b1000111;
      #1;
      checks++;
      assert (F === exp_f) else begin
         failures++;
         $error("FAIL %s F got=%b exp=%b", tag, F, exp_f);
      end
      checks++;
      assert (Buzzer === exp_b) else begin
         failures++;
         $error("FAIL %s Buzzer got=%b exp=%b", tag, Buzzer, exp_b);
      end
      checks++;
      assert (LED === exp_led) else begin
         failures++;
         $error("FAIL %s LED got=%b exp=%b", tag, LED, exp_led);
      end
   endtask

   task automatic steps(input int n, input string tag);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   initial begin
      rst  = 1'b1;
      S    = 3'b001;
      mode = 1'b0;
      steps(2, "reset");
      rst = 1'b0;
      steps(20, "idle_after_reset");

      // Single timed trigger: exactly 16 lit cycles, last 4 with buzzer.
      S[2] = ~S[2];
      hi_cnt  = 0;
      buz_cnt = 0;
      for (int i = 0; i < 24; i++) begin
         step("timed_single");
         if (F === 1'b1) hi_cnt++;
         if (Buzzer === 1'b1) buz_cnt++;
      end
      checks++;
      assert (hi_cnt == 16) else begin
         failures++;
         $error("FAIL on_time got=%0d exp=16", hi_cnt);
      end
      checks++;
      assert (buz_cnt == 4) else begin
         failures++;
         $error("FAIL buzzer_time got=%0d exp=4", buz_cnt);
      end

      // Retrigger at count 10, then again exactly at count 15.
      S[0] = ~S[0];
      step("retrig_start");
      steps(10, "retrig_run");
      S[0] = ~S[0];
      step("retrig_at10");
      steps(15, "retrig_run2");
      S[0] = ~S[0];
      step("retrig_at15");
      steps(20, "retrig_tail");

      // Toggle mode: no timeout, second flip turns off.
      mode = 1'b1;
      S[1] = ~S[1];
      steps(101, "latched_on");
      S[1] = ~S[1];
      steps(3, "latched_off");
      mode = 1'b0;
      steps(2, "idle");

      // Timed -> latched at count 8 -> back to timed.
      S[2] = ~S[2];
      step("mode_sw_start");
      steps(8, "mode_sw_run");
      mode = 1'b1;
      steps(50, "mode_sw_latched");
      mode = 1'b0;
      steps(20, "mode_sw_timed");

      // Reset mid on-period, then a full restart.
      S[1] = ~S[1];
      step("rst_mid_start");
      steps(12, "rst_mid_run");
      rst = 1'b1;
      S[0] = ~S[0];
      step("rst_mid");
      rst = 1'b0;
      steps(3, "rst_mid_after");
      S[0] = ~S[0];
      steps(20, "rst_restart");

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(5, 0) == 0) S[$urandom_range(N_SW - 1, 0)] ^= 1'b1;
         if ($urandom_range(39, 0) == 0) mode = ~mode;
         rst = ($urandom_range(149, 0) == 0);
         step("random");
      end
      rst = 1'b0;
      steps(2, "random_end");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
